// File: rtl/batt_if.sv
// batt_if: A2D battery sample input and supervisor status outputs
interface batt_if;
  logic        batt_vld;
  logic [11:0] batt;
  logic [11:0] batt_avg;
  logic        avg_vld;
  logic        batt_low;
  logic        batt_crit;
  logic [7:0]  LED;
  modport master (output batt_vld, batt, input batt_avg, avg_vld, batt_low, batt_crit, LED);
  modport slave (input batt_vld, batt, output batt_avg, avg_vld, batt_low, batt_crit, LED);
endinterface

// File: rtl/batt_monitor.sv
// batt_monitor: block-averages battery conversions and classifies NORMAL/LOW/CRIT
// with hysteresis and persistence; drives batt_low/batt_crit and an LED bar.
module batt_monitor #(
  parameter int unsigned AVG_LOG2 = 3,
  parameter logic [11:0] LOW_TH   = 12'h800,
  parameter logic [11:0] CRIT_TH  = 12'h700,
  parameter logic [11:0] HYST     = 12'h040,
  parameter int unsigned PERSIST  = 4
) (
  input logic   clk,
  input logic   rst_n,
  batt_if.slave bus
);
  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned PW = $clog2(PERSIST + 1);
  localparam logic [12:0] REC_TH = {1'b0, LOW_TH} + {1'b0, HYST};
  typedef enum logic [1:0] {NORMAL, LOW, CRIT, NONE} state_t;
  state_t r_state, r_prev, w_next, w_prev, w_cand;
  logic [AW-1:0]       r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [11:0]         r_avg;
  logic                r_avg_vld, r_low, r_crit;
  logic [7:0]          r_led;
  logic [PW-1:0]       r_pcnt, w_pcnt, w_inc;
  logic [AW-1:0]       w_sum;
  logic [11:0]         w_avg;
  logic                w_last;
  assign w_sum  = r_acc + AW'(bus.batt);
  assign w_avg  = w_sum[AW-1:AVG_LOG2];
  assign w_last = bus.batt_vld && (r_cnt == '1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
      r_led     <= '0;
    end else begin
      r_avg_vld <= w_last;
      if (bus.batt_vld) begin
        r_acc <= w_last ? '0 : w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) r_avg <= w_avg;
      // the bar is blanked on entry to CRIT and stays dark for as long as CRIT holds
      if (w_last) r_led <= (r_state == CRIT) ? 8'h00 : ~(8'hFE << w_avg[11:9]);
      else if (w_next == CRIT) r_led <= 8'h00;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= NORMAL;
      r_prev  <= NONE;
      r_pcnt  <= '0;
      r_low   <= 1'b0;
      r_crit  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prev  <= w_prev;
      r_pcnt  <= w_pcnt;
      r_low   <= w_next != NORMAL;
      r_crit  <= w_next == CRIT;
    end
  always_comb begin
    w_next = r_state;
    w_prev = r_prev;
    w_pcnt = r_pcnt;
    w_cand = r_state == CRIT ? NONE :
             r_avg < CRIT_TH ? CRIT :
             r_state == NORMAL ? (r_avg < LOW_TH ? LOW : NONE) :
             ({1'b0, r_avg} >= REC_TH ? NORMAL : NONE);
    w_inc  = (w_cand == r_prev) ? r_pcnt + 1'b1 : PW'(1);
    if (r_avg_vld) begin
      if (w_cand == NONE) begin
        w_pcnt = '0;
        w_prev = NONE;
      end else if (w_inc == PW'(PERSIST)) begin
        w_next = w_cand;
        w_pcnt = '0;
        w_prev = NONE;
      end else begin
        w_pcnt = w_inc;
        w_prev = w_cand;
      end
    end
  end
  assign bus.batt_avg  = r_avg;
  assign bus.avg_vld   = r_avg_vld;
  assign bus.batt_low  = r_low;
  assign bus.batt_crit = r_crit;
  assign bus.LED       = r_led;
endmodule

// File: tb/tb_batt_monitor.sv
// tb_batt_monitor: scoreboard bench for batt_monitor with directed windows
module tb_batt_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  batt_if bus();
  batt_monitor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {logic [11:0] avg; logic [7:0] led; logic low; logic crit;} exp_t;
  exp_t q[$];
  exp_t cur;
  logic pend = 1'b0;
  logic prev_low = 1'b0;
  logic prev_crit = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // avg_vld cycle: average checked, status must still show the old state;
  // the following cycle: status and LED must show the new state
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      prev_low = 1'b0;
      prev_crit = 1'b0;
    end else begin
      if (pend) begin
        chk("batt_low", bus.batt_low, cur.low);
        chk("batt_crit", bus.batt_crit, cur.crit);
        chk("LED", bus.LED, cur.led);
        prev_low = cur.low;
        prev_crit = cur.crit;
        pend = 1'b0;
      end
      if (bus.avg_vld) begin
        if (q.size() == 0) chk("unexpected_avg_vld", 1, 0);
        else begin
          cur = q.pop_front();
          chk("batt_avg", bus.batt_avg, cur.avg);
          chk("batt_low_early", bus.batt_low, prev_low);
          chk("batt_crit_early", bus.batt_crit, prev_crit);
          pend = 1'b1;
        end
      end
    end
  end
  task automatic send(logic [11:0] v, int gap);
    @(negedge clk);
    bus.batt_vld = 1'b1;
    bus.batt = v;
    @(negedge clk);
    bus.batt_vld = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic win(logic [11:0] v, logic [11:0] avg, logic [7:0] led, logic low, logic crit);
    q.push_back('{avg, led, low, crit});
    repeat (8) send(v, 0);
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || pend) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("drain_timeout", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_avg", bus.batt_avg, 12'h000);
    chk("rst_avg_vld", bus.avg_vld, 0);
    chk("rst_low", bus.batt_low, 0);
    chk("rst_crit", bus.batt_crit, 0);
    chk("rst_LED", bus.LED, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.batt_vld = 1'b0;
    bus.batt = '0;
    do_reset();
    win(12'hA00, 12'hA00, 8'h3F, 0, 0);
    q.push_back('{12'h7FF, 8'h0F, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) send(i % 2 ? 12'hFFF : 12'h000, i % 3);
    drain();
    do_reset();
    win(12'h7F0, 12'h7F0, 8'h0F, 0, 0);
    win(12'h7F0, 12'h7F0, 8'h0F, 0, 0);
    win(12'h7F0, 12'h7F0, 8'h0F, 0, 0);
    win(12'h7F0, 12'h7F0, 8'h0F, 1, 0);
    repeat (4) win(12'h820, 12'h820, 8'h1F, 1, 0);
    repeat (3) win(12'h840, 12'h840, 8'h1F, 1, 0);
    win(12'h840, 12'h840, 8'h1F, 0, 0);
    drain();
    do_reset();
    repeat (3) win(12'h7F0, 12'h7F0, 8'h0F, 0, 0);
    win(12'h900, 12'h900, 8'h1F, 0, 0);
    repeat (3) win(12'h7F0, 12'h7F0, 8'h0F, 0, 0);
    drain();
    do_reset();
    repeat (3) win(12'h6F0, 12'h6F0, 8'h0F, 0, 0);
    win(12'h6F0, 12'h6F0, 8'h00, 1, 1);
    repeat (10) win(12'hA00, 12'hA00, 8'h00, 1, 1);
    drain();
    repeat (5) send(12'hA00, 0);
    do_reset();
    win(12'h100, 12'h100, 8'h01, 0, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
